// File: rtl/sram_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_master
//  Description : Burst request front-end for an asynchronous-control SRAM
//                sharing a bidirectional data bus; registered read response.
//  Revision    : 1.0  initial release
// ============================================================================
module sram_bus_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    inout  wire  [DATA_W-1:0] ram_data
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_write  = 2'd1;
    localparam logic [1:0] c_st_read   = 2'd2;
    localparam logic [1:0] c_st_rdrain = 2'd3;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_rd_pend;
    logic              r_rd_pend_last;

    logic              w_wr_beat;
    logic              w_rd_phase;

    assign w_wr_beat   = (r_state == c_st_write) && wdata_valid;
    assign w_rd_phase  = (r_state == c_st_read) || (r_state == c_st_rdrain);

    assign req_ready   = (r_state == c_st_idle);
    assign wdata_ready = (r_state == c_st_write);

    // RAM strobes are gated by rst_n so no access can slip out while reset is low.
    assign ram_cs      = rst_n && (w_wr_beat || w_rd_phase);
    assign ram_we      = rst_n && w_wr_beat;
    assign ram_oe      = rst_n && w_rd_phase;
    assign ram_addr    = r_addr;
    assign ram_data    = ram_we ? wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= c_st_idle;
            r_addr         <= '0;
            r_cnt          <= '0;
            r_rd_pend      <= 1'b0;
            r_rd_pend_last <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_last       <= 1'b0;
        end else begin
            // Data for an address issued in cycle N is on the bus in N+1.
            r_rd_pend      <= (r_state == c_st_read);
            r_rd_pend_last <= (r_state == c_st_read) && (r_cnt == '0);
            rsp_valid      <= r_rd_pend;
            rsp_last       <= r_rd_pend_last;
            if (r_rd_pend) begin
                rsp_data <= ram_data;
            end

            case (r_state)
                c_st_idle: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_cnt   <= req_len;
                        r_state <= req_we ? c_st_write : c_st_read;
                    end
                end
                c_st_write: begin
                    if (wdata_valid) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        if (r_cnt == '0) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_cnt <= r_cnt - LEN_W'(1);
                        end
                    end
                end
                c_st_read: begin
                    // The last address is kept so the drain cycle presents it again.
                    if (r_cnt == '0) begin
                        r_state <= c_st_rdrain;
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_cnt  <= r_cnt - LEN_W'(1);
                    end
                end
                c_st_rdrain: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bus_master
//  Description : Directed self-checking bench with a synchronous-read SRAM model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sram_bus_master;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [LW-1:0] req_len;
    logic          wdata_valid, wdata_ready;
    logic [DW-1:0] wdata;
    logic          rsp_valid, rsp_last;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] ram_addr;
    logic          ram_cs, ram_we, ram_oe;
    wire  [DW-1:0] ram_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:255];
    logic [7:0] mem_q     = 8'h00;
    logic       mem_rd_q  = 1'b0;
    int         wr_count  = 0;
    logic [7:0] wbuf [0:15];
    logic [7:0] expb [0:15];

    always #5 clk = ~clk;

    sram_bus_master #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .ram_addr(ram_addr), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
        .ram_data(ram_data)
    );

    // Synchronous-read SRAM: data for an address seen at an edge is driven the next cycle.
    always @(posedge clk) begin
        mem_rd_q <= ram_cs && ram_oe;
        if (ram_cs && ram_oe) mem_q <= mem[ram_addr];
        if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_data;
            wr_count      <= wr_count + 1;
        end
    end
    assign ram_data = (mem_rd_q && !ram_we) ? mem_q : 8'hzz;

    always @(negedge clk) begin
        checks++;
        if (ram_we && ram_oe) begin
            errors++;
            $display("FAIL bus_we_oe: ram_we=%b ram_oe=%b, required not both 1", ram_we, ram_oe);
        end
        if (!rst_n && ram_cs) begin
            errors++;
            $display("FAIL bus_cs_in_reset: ram_cs=%b, required 0", ram_cs);
        end
        if (ram_we && ram_data !== wdata) begin
            errors++;
            $display("FAIL bus_wr_drive: ram_data=%h, required %h", ram_data, wdata);
        end else if (!ram_we && mem_rd_q && ram_data !== mem_q) begin
            errors++;
            $display("FAIL bus_contention: ram_data=%h, required %h (RAM only)", ram_data, mem_q);
        end
    end

    task automatic write_burst(input logic [7:0] a, input int n);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_len = LW'(n - 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wdata_valid = 1'b1; wdata = wbuf[i];
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0; wdata = 8'h5A;
    endtask

    task automatic read_check(input string name, input logic [7:0] a, input int n);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_len = LW'(n - 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (ram_cs !== 1'b1 || ram_oe !== 1'b1 || ram_addr !== a || req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_issue: cs=%b oe=%b addr=%h ready=%b, required 1 1 %h 0",
                             name, ram_cs, ram_oe, ram_addr, req_ready, a);
                end
            end
            checks++;
            if (c >= 3 && c <= n + 2) begin
                if (rsp_valid !== 1'b1 || rsp_data !== expb[c-3] || rsp_last !== (c == n + 2)) begin
                    errors++;
                    $display("FAIL %s_beat%0d: valid=%b data=%h last=%b, required 1 %h %b",
                             name, c - 3, rsp_valid, rsp_data, rsp_last, expb[c-3], (c == n + 2));
                end
            end else if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_idle_c%0d: rsp_valid=%b, required 0", name, c, rsp_valid);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0;
        wdata_valid = 1'b0; wdata = 8'h5A;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_last !== 1'b0 || rsp_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b last=%b data=%h, required 0 0 00", rsp_valid, rsp_last, rsp_data);
        end
        checks++;
        if (ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL reset_cs: ram_cs=%b, required 0", ram_cs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || wdata_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: req_ready=%b wdata_ready=%b, required 1 0", req_ready, wdata_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        wbuf[0] = 8'hA5;
        write_burst(8'h10, 1);
        expb[0] = 8'hA5;
        read_check("single", 8'h10, 1);
    endtask

    task automatic test_burst4;
        int cnt0;
        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03; wbuf[3] = 8'h04;
        cnt0 = wr_count;
        write_burst(8'h20, 4);
        checks++;
        if (wr_count - cnt0 !== 4) begin
            errors++;
            $display("FAIL burst4_writes: count=%0d, required 4", wr_count - cnt0);
        end
        expb[0] = 8'h01; expb[1] = 8'h02; expb[2] = 8'h03; expb[3] = 8'h04;
        read_check("burst4", 8'h20, 4);
    endtask

    task automatic test_write_stall;
        int cnt0;
        logic [7:0] d [0:3];
        d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
        cnt0 = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30; req_len = 4'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                wdata_valid = 1'b0; wdata = 8'hEE;
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if (ram_cs !== 1'b0 || wdata_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_cs: ram_cs=%b wdata_ready=%b, required 0 1", ram_cs, wdata_ready);
                    end
                    @(posedge clk); #1;
                end
            end
            wdata_valid = 1'b1; wdata = d[i];
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0; wdata = 8'h5A;
        @(negedge clk);
        checks++;
        if (wr_count - cnt0 !== 4 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_writes: count=%0d ready=%b, required 4 1", wr_count - cnt0, req_ready);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) expb[i] = d[i];
        read_check("stall", 8'h30, 4);
    endtask

    task automatic test_wrap;
        wbuf[0] = 8'hC1; wbuf[1] = 8'hC2; wbuf[2] = 8'hC3;
        write_burst(8'hFE, 3);
        expb[0] = 8'hC1; expb[1] = 8'hC2; expb[2] = 8'hC3;
        read_check("wrap", 8'hFE, 3);
        expb[0] = 8'hC3;
        read_check("wrap00", 8'h00, 1);
    endtask

    task automatic test_ignore_req;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h50; req_len = 4'd1;
        @(posedge clk); #1;
        req_we = 1'b0; req_addr = 8'h60;
        wdata_valid = 1'b1; wdata = 8'h77;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ignore_ready: req_ready=%b, required 0", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; wdata = 8'h88;
        @(posedge clk); #1;
        wdata_valid = 1'b0; wdata = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (ram_oe !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL ignore_noread: ram_oe=%b rsp_valid=%b, required 0 0", ram_oe, rsp_valid);
            end
            @(posedge clk); #1;
        end
        expb[0] = 8'h77; expb[1] = 8'h88;
        read_check("ignore", 8'h50, 2);
    endtask

    task automatic test_reset_mid_read;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_len = 4'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL midrst_cs: ram_cs=%b, required 0", ram_cs);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || ram_cs !== 1'b0) begin
            errors++;
            $display("FAIL midrst_hold: rsp_valid=%b ram_cs=%b, required 0 0", rsp_valid, ram_cs);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: req_ready=%b, required 1", req_ready);
        end
        repeat (8) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || ram_cs !== 1'b0) begin
                errors++;
                $display("FAIL midrst_quiet: rsp_valid=%b ram_cs=%b, required 0 0", rsp_valid, ram_cs);
            end
        end
        @(posedge clk); #1;
        expb[0] = 8'h02;
        read_check("post_rst", 8'h21, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_burst4();
        test_write_stall();
        test_wrap();
        test_ignore_req();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_bus_master.md
SRAM_BUS_MASTER -- requirements
Module: sram_bus_master

Interface
REQ-001 Parameters SHALL be: DATA_W, default 8, word width; ADDR_W, default 8, address width; LEN_W, default 4, burst-length field width.
REQ-002 clk  input  1  sole clock; all registers update on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req_valid  input  1  burst request present.
REQ-005 req_ready  output  1  controller accepts a request this cycle.
REQ-006 req_we  input  1  1 = write burst, 0 = read burst.
REQ-007 req_addr  input  ADDR_W  burst start address.
REQ-008 req_len  input  LEN_W  beats minus one (0 = 1 beat, max 2^LEN_W beats).
REQ-009 wdata_valid  input  1  write beat available.
REQ-010 wdata_ready  output  1  controller consumes the write beat this cycle.
REQ-011 wdata  input  DATA_W  write beat data.
REQ-012 rsp_valid  output  1  read beat valid (no backpressure).
REQ-013 rsp_data  output  DATA_W  read beat data.
REQ-014 rsp_last  output  1  marks final read beat of a burst.
REQ-015 ram_addr  output  ADDR_W  RAM address.
REQ-016 ram_cs, ram_we, ram_oe  output  1 each  RAM chip select, write enable, output enable.
REQ-017 ram_data  inout  DATA_W  shared RAM data bus; controller drives only while ram_we=1, otherwise high-Z.

Function
REQ-018 States SHALL be IDLE, WRITE, READ, RDRAIN.
REQ-019 IDLE: req_ready=1, ram_cs=0; on req_valid&&req_ready the controller latches addr/len/we and moves to WRITE (req_we=1) or READ (req_we=0); req_ready=0 in all other states.
REQ-020 WRITE: wdata_ready=1; in a cycle with wdata_valid=1: ram_cs=1, ram_we=1, ram_oe=0, ram_addr=current address, ram_data=wdata (combinational); address increments and beat count decrements at cycle end.
REQ-021 WRITE with wdata_valid=0: ram_cs=0, ram_data high-Z, address/count held (stall, unlimited length).
REQ-022 WRITE SHALL return to IDLE after the edge that consumes beat req_len+1.
REQ-023 READ: ram_cs=1, ram_oe=1, ram_we=0, ram_addr=current address; address increments every cycle; after issuing address of the last beat, next state RDRAIN.
REQ-024 RDRAIN: ram_cs=1, ram_oe=1, ram_we=0, ram_addr held at last address; next state IDLE.
REQ-025 Read capture: ram_data sampled at the end of each cycle following an issued read address; registered into rsp_data with rsp_valid=1 in the next cycle.
REQ-026 Read latency: request accepted in cycle C0; beat i SHALL appear on rsp_valid/rsp_data in cycle C3+i; rsp_last=1 only with the final beat, coinciding with the first IDLE cycle.
REQ-027 Address SHALL wrap modulo 2^ADDR_W (e.g. 8'hFF -> 8'h00) with no error.
REQ-028 At least one IDLE cycle SHALL separate consecutive bursts; ram_we and ram_oe SHALL never both be 1.
REQ-029 Requests presented while req_ready=0 SHALL be ignored, not queued.

Reset
REQ-030 While rst_n=0 at a rising edge: state=IDLE, address/count cleared, rsp_valid=0, rsp_data=0, rsp_last=0.
REQ-031 ram_cs SHALL be gated by rst_n combinationally so no RAM access occurs in any cycle with rst_n=0; ram_data high-Z.
REQ-032 Reset mid-burst SHALL abandon the burst; no further rsp_valid pulses from that burst; req_ready=1 in the first cycle after reset release.

Verification
REQ-033 Single write then read: write addr 8'h10 len 0 data 8'hA5; read addr 8'h10 len 0 -> rsp_data=8'hA5 in C3, rsp_last=1.
REQ-034 Burst 4 write 8'h20..8'h23 data 1,2,3,4; read burst 4 -> rsp_valid C3..C6, data 1,2,3,4, rsp_last only at C6.
REQ-035 Write stall: wdata_valid low for 3 cycles mid-burst -> ram_cs=0 those cycles, no extra writes, readback correct.
REQ-036 Wrap: write burst 3 at 8'hFE -> locations FE, FF, 00 written; readback matches.
REQ-037 Reset during read burst of 8 after beat 2 -> rsp_valid stays 0, ram_cs=0, req_ready=1 the cycle after release.
REQ-038 Bus checker every cycle: ram_data driven by controller only when ram_we=1; ram_we&&ram_oe never 1.
